// File: rtl/pixel_align_pkg.sv
// -----------------------------------------------------------------------------
// pixel_align_pkg
// Shared definitions for the pixel alignment delay line:
//   - default parameter constants
//   - fill-state enum (EMPTY, FILLING, PRIMED)
//   - clamp_delay(): maps a requested delay onto the legal range 1..max_delay
// No ports; imported by the interface, the lane sub-module and the top.
// -----------------------------------------------------------------------------
package pixel_align_pkg;

    localparam int PIXEL_W_DEF   = 8;
    localparam int CHANNELS_DEF  = 3;
    localparam int MAX_DELAY_DEF = 7;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        PRIMED  = 2'd2
    } state_t;

    // A request of 0 would mean "no delay", which the line cannot express
    // without a combinational in->out path, so it is promoted to 1.
    function automatic int unsigned clamp_delay(input int unsigned req,
                                                input int unsigned max_delay);
        int unsigned res;
        if (req == 0)
            res = 1;
        else if (req > max_delay)
            res = max_delay;
        else
            res = req;
        return res;
    endfunction

endpackage

// File: rtl/pixel_align_unit_if.sv
// -----------------------------------------------------------------------------
// pixel_align_unit_if
// Bundles the stream and configuration signals of pixel_align_unit.
//   en         advance strobe
//   in_valid   / in_pixel    input sample stream
//   cfg_delay  / cfg_load    delay configuration (load also flushes)
//   out_valid  / out_pixel   delayed sample stream
//   primed     line filled to the active delay since the last flush
//   cur_delay  active delay
//   out_count  valid-output counter (only with PIXEL_ALIGN_STATS_EN)
// Modports: master drives the inputs (testbench / upstream), slave is the DUT.
// -----------------------------------------------------------------------------
interface pixel_align_unit_if #(
    parameter int PIXEL_W   = pixel_align_pkg::PIXEL_W_DEF,
    parameter int CHANNELS  = pixel_align_pkg::CHANNELS_DEF,
    parameter int MAX_DELAY = pixel_align_pkg::MAX_DELAY_DEF,
    parameter int DELAY_W   = $clog2(MAX_DELAY + 1)
) ();

    logic                          en;
    logic                          in_valid;
    logic [CHANNELS*PIXEL_W-1:0]   in_pixel;
    logic [DELAY_W-1:0]            cfg_delay;
    logic                          cfg_load;
    logic                          out_valid;
    logic [CHANNELS*PIXEL_W-1:0]   out_pixel;
    logic                          primed;
    logic [DELAY_W-1:0]            cur_delay;
`ifdef PIXEL_ALIGN_STATS_EN
    logic [15:0]                   out_count;
`endif

    modport master (
`ifdef PIXEL_ALIGN_STATS_EN
        input  out_count,
`endif
        output en, in_valid, in_pixel, cfg_delay, cfg_load,
        input  out_valid, out_pixel, primed, cur_delay
    );

    modport slave (
`ifdef PIXEL_ALIGN_STATS_EN
        output out_count,
`endif
        input  en, in_valid, in_pixel, cfg_delay, cfg_load,
        output out_valid, out_pixel, primed, cur_delay
    );

endinterface

// File: rtl/pixel_shift_lane.sv
// -----------------------------------------------------------------------------
// pixel_shift_lane
// One channel's MAX_DELAY x PIXEL_W shift register with a tap mux.
//   clk, rst  clock, asynchronous active-high reset
//   en        shift strobe
//   din       sample entering stage 1
//   tap       selected stage, 1..MAX_DELAY
//   dout      contents of stage 'tap'
// -----------------------------------------------------------------------------
module pixel_shift_lane
    import pixel_align_pkg::*;
#(
    parameter int PIXEL_W   = PIXEL_W_DEF,
    parameter int MAX_DELAY = MAX_DELAY_DEF,
    parameter int DELAY_W   = $clog2(MAX_DELAY + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PIXEL_W-1:0] din,
    input  logic [DELAY_W-1:0] tap,
    output logic [PIXEL_W-1:0] dout
);

    logic [PIXEL_W-1:0] stage [MAX_DELAY];

    // NOTE: this storage is normally left unreset, but out_pixel must read 0
    // the instant rst asserts, so every stage sits on the async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MAX_DELAY; k++)
                stage[k] <= '0;
        end else if (en) begin
            // NOTE: non-blocking makes every stage read its neighbour's old
            // value, so the loop order does not matter.
            stage[0] <= din;
            for (int k = 1; k < MAX_DELAY; k++)
                stage[k] <= stage[k-1];
        end
    end

    // Stage k is index k-1; an equality scan avoids an out-of-range index.
    always_comb begin
        // NOTE: default first so no path leaves dout unassigned (no latch).
        dout = '0;
        for (int k = 0; k < MAX_DELAY; k++)
            if (tap == DELAY_W'(k + 1))
                dout = stage[k];
    end

endmodule

// File: rtl/pixel_align_unit.sv
// -----------------------------------------------------------------------------
// pixel_align_unit
// Programmable-latency delay line for CHANNELS parallel pixel samples.
// Output is stage D of a MAX_DELAY-deep shift register, D = cur_delay.
//   clk   sole clock
//   rst   asynchronous active-high reset
//   bus   pixel_align_unit_if.slave (stream, configuration, status)
// Optional: define PIXEL_ALIGN_STATS_EN to add the 16-bit saturating
// bus.out_count of advances that leave out_valid high.
// -----------------------------------------------------------------------------
module pixel_align_unit
    import pixel_align_pkg::*;
#(
    parameter int PIXEL_W   = PIXEL_W_DEF,
    parameter int CHANNELS  = CHANNELS_DEF,
    parameter int MAX_DELAY = MAX_DELAY_DEF,
    parameter int DELAY_W   = $clog2(MAX_DELAY + 1)
) (
    input  logic               clk,
    input  logic               rst,
    pixel_align_unit_if.slave  bus
);

    localparam logic [DELAY_W-1:0] ONE = DELAY_W'(1);

    state_t                     state, state_n;
    logic [DELAY_W-1:0]         cur_delay, delay_n;
    logic [DELAY_W-1:0]         fill_cnt, fill_n;
    logic [DELAY_W-1:0]         load_delay;
    logic [MAX_DELAY-1:0]       vld, vld_n;
    logic [CHANNELS*PIXEL_W-1:0] pix_out;

    // Valid bit of stage d (1-based) of a valid vector.
    function automatic logic tap_valid(input logic [MAX_DELAY-1:0] v,
                                       input logic [DELAY_W-1:0]   d);
        logic r;
        r = 1'b0;
        for (int k = 0; k < MAX_DELAY; k++)
            if (d == DELAY_W'(k + 1))
                r = v[k];
        return r;
    endfunction

    assign load_delay = DELAY_W'(clamp_delay(32'(bus.cfg_delay), MAX_DELAY));
    assign delay_n    = bus.cfg_load ? load_delay : cur_delay;

    // ---------------- data lanes -------------------------------------------
    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        pixel_shift_lane #(
            .PIXEL_W   (PIXEL_W),
            .MAX_DELAY (MAX_DELAY),
            .DELAY_W   (DELAY_W)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .en   (bus.en),
            .din  (bus.in_pixel[c*PIXEL_W +: PIXEL_W]),
            .tap  (cur_delay),
            .dout (pix_out[c*PIXEL_W +: PIXEL_W])
        );
    end

    // ---------------- valid tracking ---------------------------------------
    // A load flushes the in-flight valids; data registers keep their contents
    // and are masked by the cleared valids.
    always_comb begin
        vld_n = vld;
        if (bus.cfg_load) begin
            vld_n = '0;
            if (bus.en)
                vld_n[0] = bus.in_valid;
        end else if (bus.en) begin
            vld_n[0] = bus.in_valid;
            for (int k = 1; k < MAX_DELAY; k++)
                vld_n[k] = vld[k-1];
        end
    end

    // ---------------- fill state machine -----------------------------------
    always_comb begin
        state_n = state;
        fill_n  = fill_cnt;
        if (bus.cfg_load) begin
            if (bus.en) begin
                // The load edge itself is the first advance of the new fill.
                fill_n  = ONE;
                state_n = (load_delay == ONE) ? PRIMED : FILLING;
            end else begin
                fill_n  = '0;
                state_n = EMPTY;
            end
        end else if (bus.en) begin
            case (state)
                EMPTY: begin
                    fill_n  = ONE;
                    state_n = (cur_delay == ONE) ? PRIMED : FILLING;
                end
                FILLING: begin
                    // fill_cnt < cur_delay here, so the increment cannot wrap.
                    fill_n = fill_cnt + ONE;
                    if (fill_cnt + ONE >= cur_delay)
                        state_n = PRIMED;
                end
                PRIMED:  ;   // counter is saturated at D
                default: begin
                    fill_n  = '0;
                    state_n = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            fill_cnt  <= '0;
            cur_delay <= DELAY_W'(MAX_DELAY);
            vld       <= '0;
        end else begin
            state     <= state_n;
            fill_cnt  <= fill_n;
            cur_delay <= delay_n;
            vld       <= vld_n;
        end
    end

    // ---------------- outputs ----------------------------------------------
    assign bus.out_pixel = pix_out;
    assign bus.out_valid = tap_valid(vld, cur_delay);
    assign bus.primed    = (state == PRIMED);
    assign bus.cur_delay = cur_delay;

`ifdef PIXEL_ALIGN_STATS_EN
    logic [15:0] out_count;

    // Counts advances whose post-edge out_valid is high, so the decision
    // uses the next-state valid vector and delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_count <= '0;
        else if (bus.cfg_load)
            out_count <= '0;
        else if (bus.en && tap_valid(vld_n, delay_n) && (out_count != 16'hFFFF))
            out_count <= out_count + 16'd1;
    end

    assign bus.out_count = out_count;
`endif

endmodule

// File: tb/tb_pixel_align_unit.sv
// -----------------------------------------------------------------------------
// tb_pixel_align_unit
// Self-checking bench for pixel_align_unit. A sample-history model (queues of
// past samples plus a count of advances since the last flush) predicts every
// output; directed scenarios cover delay, stall, bubbles, clamping, reload and
// asynchronous reset, followed by randomized traffic.
// Checks bus.out_count as well when PIXEL_ALIGN_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_pixel_align_unit;

    localparam int PIXEL_W   = 8;
    localparam int CHANNELS  = 3;
    localparam int MAX_DELAY = 7;
    localparam int DELAY_W   = $clog2(MAX_DELAY + 1);
    localparam int PW        = CHANNELS * PIXEL_W;

    logic clk;
    logic rst;

    pixel_align_unit_if #(
        .PIXEL_W(PIXEL_W), .CHANNELS(CHANNELS),
        .MAX_DELAY(MAX_DELAY), .DELAY_W(DELAY_W)
    ) bus ();

    pixel_align_unit #(
        .PIXEL_W(PIXEL_W), .CHANNELS(CHANNELS),
        .MAX_DELAY(MAX_DELAY), .DELAY_W(DELAY_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model --------------------------------------
    // m_data/m_vq hold the last MAX_DELAY samples, newest at index 0.
    // A sample at index i is valid at the output only if it was pushed after
    // the last flush, i.e. i < m_fill.
    logic [PW-1:0] m_data [$];
    bit            m_vq   [$];
    int            m_d;
    int            m_fill;
    int            m_count;

    function automatic bit m_ov();
        return (m_fill >= m_d) && m_vq[m_d-1];
    endfunction

    task automatic model_reset();
        m_data.delete();
        m_vq.delete();
        for (int i = 0; i < MAX_DELAY; i++) begin
            m_data.push_back('0);
            m_vq.push_back(1'b0);
        end
        m_d     = MAX_DELAY;
        m_fill  = 0;
        m_count = 0;
    endtask

    task automatic model_edge(input bit en, input bit v, input logic [PW-1:0] pix,
                              input bit load, input logic [DELAY_W-1:0] cfg);
        if (load) begin
            m_d    = (cfg == 0) ? 1 : ((int'(cfg) > MAX_DELAY) ? MAX_DELAY : int'(cfg));
            m_fill = 0;
        end
        if (en) begin
            m_data.push_front(pix);
            m_vq.push_front(v);
            void'(m_data.pop_back());
            void'(m_vq.pop_back());
            if (m_fill < 1000)
                m_fill++;
        end
        if (load)
            m_count = 0;
        else if (en && m_ov() && m_count < 65535)
            m_count++;
    endtask

    task automatic check_all();
        check("out_valid", 64'(bus.out_valid), 64'(m_ov()));
        check("out_pixel", 64'(bus.out_pixel), 64'(m_data[m_d-1]));
        check("primed",    64'(bus.primed),    64'(m_fill >= m_d));
        check("cur_delay", 64'(bus.cur_delay), 64'(m_d));
`ifdef PIXEL_ALIGN_STATS_EN
        check("out_count", 64'(bus.out_count), 64'(m_count));
`endif
    endtask

    // One clock: drive inputs, let the edge happen, update the model, then
    // compare at the falling edge.
    task automatic cyc(input bit en, input bit v, input logic [PW-1:0] pix,
                       input bit load, input logic [DELAY_W-1:0] cfg);
        bus.en        = en;
        bus.in_valid  = v;
        bus.in_pixel  = pix;
        bus.cfg_load  = load;
        bus.cfg_delay = cfg;
        @(posedge clk);
        model_edge(en, v, pix, load, cfg);
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [PW-1:0] rep(input logic [7:0] val);
        logic [PW-1:0] r;
        for (int c = 0; c < CHANNELS; c++)
            r[c*PIXEL_W +: PIXEL_W] = PIXEL_W'(val);
        return r;
    endfunction

    // ---------------- stimulus ---------------------------------------------
    initial begin
        bit                 pat [4];
        logic [DELAY_W-1:0] c15;

        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pixel  = '0;
        bus.cfg_load  = 1'b0;
        bus.cfg_delay = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        check("reset_delay", 64'(bus.cur_delay), 64'(MAX_DELAY));
        rst = 1'b0;

        // Basic delay, D=3, ramp 1,2,3,...
        cyc(1'b0, 1'b0, '0, 1'b1, DELAY_W'(3));
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b1, 1'b1, rep(8'(i)), 1'b0, '0);
            if (i == 2) check("basic_primed_early", 64'(bus.primed), 64'(0));
            if (i == 3) begin
                check("basic_pix",    64'(bus.out_pixel), 64'(rep(8'h01)));
                check("basic_valid",  64'(bus.out_valid), 64'(1));
                check("basic_primed", 64'(bus.primed),    64'(1));
            end
        end

        // Stall, D=4: five dead cycles mid-ramp.
        cyc(1'b0, 1'b0, '0, 1'b1, DELAY_W'(4));
        for (int i = 1; i <= 6; i++) cyc(1'b1, 1'b1, rep(8'(8'h10 + i)), 1'b0, '0);
        repeat (5) cyc(1'b0, 1'b1, rep(8'hEE), 1'b0, '0);
        for (int i = 7; i <= 12; i++) begin
            cyc(1'b1, 1'b1, rep(8'(8'h10 + i)), 1'b0, '0);
            if (i == 7) check("stall_resume", 64'(bus.out_pixel), 64'(rep(8'h14)));
        end

        // Bubbles, D=2: valid pattern 1,0,1,1.
        pat = '{1'b1, 1'b0, 1'b1, 1'b1};
        cyc(1'b0, 1'b0, '0, 1'b1, DELAY_W'(2));
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b1, (i <= 4) ? pat[i-1] : 1'b0, rep(8'(8'h20 + i)), 1'b0, '0);
            if (i >= 2 && i <= 5)
                check("bubble_valid", 64'(bus.out_valid), 64'(pat[i-2]));
        end

        // Clamping.
        cyc(1'b0, 1'b0, '0, 1'b1, '0);
        check("clamp_zero", 64'(bus.cur_delay), 64'(1));
        c15 = DELAY_W'(15);
        cyc(1'b0, 1'b0, '0, 1'b1, c15);
        check("clamp_max", 64'(bus.cur_delay), 64'(MAX_DELAY));

        // Reload while primed: D=5, then load 2 with en=1.
        cyc(1'b0, 1'b0, '0, 1'b1, DELAY_W'(5));
        for (int i = 1; i <= 7; i++) cyc(1'b1, 1'b1, rep(8'(8'h30 + i)), 1'b0, '0);
        check("reload_pre_primed", 64'(bus.primed), 64'(1));
        cyc(1'b1, 1'b1, rep(8'h40), 1'b1, DELAY_W'(2));
        check("reload_valid_low",  64'(bus.out_valid), 64'(0));
        check("reload_primed_low", 64'(bus.primed),    64'(0));
        cyc(1'b1, 1'b1, rep(8'h41), 1'b0, '0);
        check("reload_pix",    64'(bus.out_pixel), 64'(rep(8'h40)));
        check("reload_valid",  64'(bus.out_valid), 64'(1));
        check("reload_primed", 64'(bus.primed),    64'(1));

        // Asynchronous reset between edges.
        cyc(1'b0, 1'b0, '0, 1'b1, DELAY_W'(3));
        for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b1, rep(8'(8'h50 + i)), 1'b0, '0);
        check("areset_pre_valid", 64'(bus.out_valid), 64'(1));
        bus.en = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("areset_valid",  64'(bus.out_valid), 64'(0));
        check("areset_pixel",  64'(bus.out_pixel), 64'(0));
        check("areset_primed", 64'(bus.primed),    64'(0));
        check("areset_delay",  64'(bus.cur_delay), 64'(MAX_DELAY));
`ifdef PIXEL_ALIGN_STATS_EN
        check("areset_count",  64'(bus.out_count), 64'(0));
`endif
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 9; i++) cyc(1'b1, 1'b1, rep(8'(8'h60 + i)), 1'b0, '0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0,
                $urandom_range(0, 4) != 0,
                PW'($urandom),
                $urandom_range(0, 32) == 0,
                DELAY_W'($urandom_range(0, (1 << DELAY_W) - 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
